// File: rtl/perm_gen_if.sv
// Request/result bundle between the permutation engine and its consumer.
// `sequence` is a reserved word, so the packed permutation travels as `seq`.
interface perm_gen_if #(
  parameter int N  = 8,
  parameter int EW = 4
);
  logic            req;
  logic [N*EW-1:0] seq;
  logic            busy;
  logic            done;
  logic [15:0]     perm_idx;
`ifdef PERM_WRAP_EN
  logic            wrap;
`endif

  modport master (
    input  req,
    output seq, busy, done, perm_idx
`ifdef PERM_WRAP_EN
    , output wrap
`endif
  );

  modport slave (
    output req,
    input  seq, busy, done, perm_idx
`ifdef PERM_WRAP_EN
    , input wrap
`endif
  );
endinterface

// File: rtl/perm_gen.sv
// Lexicographic next-permutation engine: FIND -> SWAP -> REV per request.
// Optional PERM_WRAP_EN restarts at identity instead of stopping in FINISH.
module perm_gen #(
  parameter int N  = 8,
  parameter int EW = 4
) (
  input  logic       CLK,
  input  logic       RST,
  perm_gen_if.master bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIND   = 3'd1,
    S_SWAP   = 3'd2,
    S_REV    = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   a_q [N];
  logic [EW-1:0]   a_d [N];
  logic [IW-1:0]   p_q, p_d, s_q, s_d;
  logic [N*EW-1:0] seq_q, seq_d;
  logic [15:0]     idx_q, idx_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            piv_found_s;
  logic [IW-1:0]   piv_s, succ_s;
`ifdef PERM_WRAP_EN
  logic            wrap_q, wrap_d, nopiv_q, nopiv_d;
`endif

  function automatic logic [N*EW-1:0] ident_seq();
    logic [N*EW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[EW*k +: EW] = EW'(k);
    return r;
  endfunction

  // Pivot and successor search; later hits overwrite earlier ones to get the largest index.
  always_comb begin
    piv_found_s = 1'b0;
    piv_s       = '0;
    succ_s      = '0;
    for (int i = 0; i < N-1; i++) begin
      piv_found_s = (a_q[i] < a_q[i+1]) ? 1'b1 : piv_found_s;
      piv_s       = (a_q[i] < a_q[i+1]) ? IW'(i) : piv_s;
    end
    for (int j = 0; j < N; j++) begin
      succ_s = ((IW'(j) > piv_s) && (a_q[j] > a_q[piv_s])) ? IW'(j) : succ_s;
    end
  end

  // Next-state, working array and output register updates.
  always_comb begin
    logic [IW-1:0] src;
    src     = '0;
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    s_d     = s_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
`ifdef PERM_WRAP_EN
    wrap_d  = 1'b0;
    nopiv_d = nopiv_q;
`endif
    case (state_q)
      S_IDLE: state_d = bus.req ? S_FIND : S_IDLE;
      S_FIND: begin
        p_d = piv_s;
        s_d = succ_s;
        if (piv_found_s) begin
          state_d = S_SWAP;
        end else begin
`ifdef PERM_WRAP_EN
          nopiv_d = 1'b1;
          state_d = S_REV;
`else
          state_d = S_FINISH;
`endif
        end
      end
      S_SWAP: begin
        a_d[p_q] = a_q[s_q];
        a_d[s_q] = a_q[p_q];
        state_d  = S_REV;
      end
      S_REV: begin
        // Position k > p takes element N+p-k, mirroring the tail about its centre.
        for (int k = 0; k < N; k++) begin
          src    = IW'(N) + p_q - IW'(k);
          a_d[k] = (IW'(k) > p_q) ? a_q[src] : a_q[k];
        end
        idx_d = idx_q + 16'd1;
`ifdef PERM_WRAP_EN
        if (nopiv_q) begin
          for (int k = 0; k < N; k++) a_d[k] = EW'(k);
          idx_d   = 16'd0;
          wrap_d  = 1'b1;
          nopiv_d = 1'b0;
        end else begin
          nopiv_d = 1'b0;
        end
`endif
        for (int k = 0; k < N; k++) seq_d[EW*k +: EW] = a_d[k];
        state_d = S_IDLE;
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FIND) || (state_d == S_SWAP) || (state_d == S_REV);
    done_d = (state_d == S_FINISH);
  end

  // State and datapath registers with synchronous reset to the identity permutation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      for (int k = 0; k < N; k++) a_q[k] <= EW'(k);
      p_q     <= '0;
      s_q     <= '0;
      seq_q   <= ident_seq();
      idx_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PERM_WRAP_EN
      wrap_q  <= 1'b0;
      nopiv_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      s_q     <= s_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PERM_WRAP_EN
      wrap_q  <= wrap_d;
      nopiv_q <= nopiv_d;
`endif
    end
  end

  assign bus.seq      = seq_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.perm_idx = idx_q;
`ifdef PERM_WRAP_EN
  assign bus.wrap     = wrap_q;
`endif
endmodule

// File: tb/tb_perm_gen.sv
// Directed bench for perm_gen: an N=8 instance for sequencing and an N=4
// instance to reach the last permutation quickly.
module tb_perm_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perm_gen_if #(.N(8), .EW(4)) bus8();
  perm_gen_if #(.N(4), .EW(4)) bus4();

  perm_gen #(.N(8), .EW(4)) dut8 (.CLK(clk), .RST(rst), .bus(bus8));
  perm_gen #(.N(4), .EW(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        hold;
    logic [31:0] seq;
    logic [15:0] idx;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit valid_perm8(input logic [31:0] s);
    bit [7:0] seen;
    logic [3:0] e;
    seen = 8'd0;
    for (int k = 0; k < 8; k++) begin
      e = s[4*k +: 4];
      if (e > 4'd7) return 1'b0;
      if (seen[e[2:0]]) return 1'b0;
      seen[e[2:0]] = 1'b1;
    end
    return 1'b1;
  endfunction

  // Reference next permutation: descending scans and a two-pointer tail reversal.
  function automatic logic [31:0] next_perm8(input logic [31:0] s);
    int a [8];
    int i, j, t, lo, hi;
    logic [31:0] r;
    for (int k = 0; k < 8; k++) a[k] = int'(s[4*k +: 4]);
    i = 6;
    while (i >= 0 && a[i] >= a[i+1]) i--;
    if (i < 0) return s;
    j = 7;
    while (a[j] <= a[i]) j--;
    t = a[i]; a[i] = a[j]; a[j] = t;
    lo = i + 1;
    hi = 7;
    while (lo < hi) begin
      t = a[lo]; a[lo] = a[hi]; a[hi] = t;
      lo++;
      hi--;
    end
    r = 32'd0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'(a[k]);
    return r;
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    bus8.req = 1'b0;
    bus4.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request from a negedge and checks the 3-cycle busy window and the result.
  task automatic advance8(input logic hold, input logic [31:0] prev,
                          input logic [31:0] exp_seq, input logic [15:0] exp_idx);
    bus8.req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!hold) bus8.req = 1'b0;
      check("adv_busy", bus8.busy, 1'b1);
      check("adv_stable", bus8.seq, prev);
    end
    @(negedge clk);
    bus8.req = 1'b0;
    check("adv_busy_low", bus8.busy, 1'b0);
    check("adv_seq", bus8.seq, exp_seq);
    check("adv_idx", bus8.perm_idx, exp_idx);
    check("adv_done", bus8.done, 1'b0);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] exp;

    vecs[0] = '{1'b0, 32'h67543210, 16'd1};
    vecs[1] = '{1'b1, 32'h75643210, 16'd2};
    vecs[2] = '{1'b0, 32'h57643210, 16'd3};
    vecs[3] = '{1'b1, 32'h65743210, 16'd4};
    vecs[4] = '{1'b0, 32'h56743210, 16'd5};
    vecs[5] = '{1'b0, 32'h76453210, 16'd6};

    bus8.req = 1'b0;
    bus4.req = 1'b0;
    do_reset();
    check("rst_seq", bus8.seq, 32'h76543210);
    check("rst_busy", bus8.busy, 1'b0);
    check("rst_done", bus8.done, 1'b0);
    check("rst_idx", bus8.perm_idx, 16'd0);
    check("rst_seq4", bus4.seq, 16'h3210);

    prev = 32'h76543210;
    for (int v = 0; v < 6; v++) begin
      advance8(vecs[v].hold, prev, vecs[v].seq, vecs[v].idx);
      prev = vecs[v].seq;
    end

    // Continuous request from reset: one advance every 4 cycles.
    do_reset();
    exp = 32'h76543210;
    bus8.req = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c % 4 == 0) begin
        exp = next_perm8(exp);
        check("cont_valid", valid_perm8(bus8.seq), 1'b1);
      end
      check("cont_seq", bus8.seq, exp);
      check("cont_busy", bus8.busy, (c % 4 != 0));
      check("cont_idx", bus8.perm_idx, 16'(c / 4));
    end
    bus8.req = 1'b0;
    check("cont_idx100", bus8.perm_idx, 16'd100);

    // Run the N=4 engine through all 23 advances to its last permutation.
    do_reset();
    bus4.req = 1'b1;
    repeat (92) @(negedge clk);
    bus4.req = 1'b0;
    check("last_seq", bus4.seq, 16'h0123);
    check("last_idx", bus4.perm_idx, 16'd23);
    check("last_done", bus4.done, 1'b0);
    check("last_busy", bus4.busy, 1'b0);
    bus4.req = 1'b1;
    @(negedge clk);
    bus4.req = 1'b0;
    check("end_find_busy", bus4.busy, 1'b1);
`ifdef PERM_WRAP_EN
    check("wrap_early", bus4.wrap, 1'b0);
    @(negedge clk);
    check("wrap_rev_busy", bus4.busy, 1'b1);
    @(negedge clk);
    check("wrap_busy", bus4.busy, 1'b0);
    check("wrap_pulse", bus4.wrap, 1'b1);
    check("wrap_seq", bus4.seq, 16'h3210);
    check("wrap_idx", bus4.perm_idx, 16'd0);
    check("wrap_done", bus4.done, 1'b0);
    @(negedge clk);
    check("wrap_one_cycle", bus4.wrap, 1'b0);
`else
    @(negedge clk);
    check("fin_busy", bus4.busy, 1'b0);
    check("fin_done", bus4.done, 1'b1);
    check("fin_seq", bus4.seq, 16'h0123);
    bus4.req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("fin_ign_busy", bus4.busy, 1'b0);
      check("fin_ign_done", bus4.done, 1'b1);
    end
    bus4.req = 1'b0;
    check("fin_ign_seq", bus4.seq, 16'h0123);
    check("fin_ign_idx", bus4.perm_idx, 16'd23);
`endif

    // Reset landing while the engine sits in SWAP discards the partial work.
    do_reset();
    bus8.req = 1'b1;
    @(negedge clk);
    bus8.req = 1'b0;
    @(negedge clk);
    check("mid_busy", bus8.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_seq", bus8.seq, 32'h76543210);
    check("mid_rst_busy", bus8.busy, 1'b0);
    check("mid_rst_idx", bus8.perm_idx, 16'd0);
    check("mid_rst_done", bus8.done, 1'b0);
    advance8(1'b0, 32'h76543210, 32'h67543210, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
